// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the multi-port register file.
package reg_file_pkg;

    localparam int unsigned DEFAULT_XLEN  = 32;
    localparam int unsigned DEFAULT_DEPTH = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/reg_clear_seq.sv
// Clear sequencer: walks an index over the whole array after reset or on
// request, one entry per cycle, and reports when the array is usable.
module reg_clear_seq
    import reg_file_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear_req,
    output logic                       clear_en,
    output logic [$clog2(DEPTH)-1:0]   clear_idx,
    output logic                       ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    // One extra bit so DEPTH = 2^AW terminates without wrapping
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;

    // State, counter and registered status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            ready    <= 1'b0;
            clear_en <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready    <= (state_d == READY);
            clear_en <= (state_d == CLEAR);
        end
    end

    // Next-state: CLEAR counts 0..DEPTH-1, READY re-enters CLEAR on request
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            READY: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    assign clear_idx = AW'(cnt_q);

endmodule

// File: rtl/reg_file_mp.sv
// Two-read / one-write register file with optional hardwired zero register,
// optional write-to-read forwarding and a sequenced array clear.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int unsigned XLEN     = DEFAULT_XLEN,
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear_req,
    output logic                       ready,
    input  logic [$clog2(DEPTH)-1:0]   rs1In,
    input  logic [$clog2(DEPTH)-1:0]   rs2In,
    input  logic                       readEnable,
    output logic [XLEN-1:0]            rs1Out,
    output logic [XLEN-1:0]            rs2Out,
    input  logic                       writeEnable,
    input  logic [$clog2(DEPTH)-1:0]   rd,
    input  logic [XLEN-1:0]            data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

    logic [XLEN-1:0] regs [DEPTH];

    logic            clear_en;
    logic [AW-1:0]   clear_idx;
    logic            wr_acc_c;
    logic [XLEN-1:0] rd1_c;
    logic [XLEN-1:0] rd2_c;

    // Address maps to real storage (in range and not the hardwired zero)
    function automatic logic addr_valid(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W) && !(ZERO_REG && (a == '0));
    endfunction

    reg_clear_seq #(
        .DEPTH (DEPTH)
    ) u_clear_seq (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .clear_en  (clear_en),
        .clear_idx (clear_idx),
        .ready     (ready)
    );

    // A write coinciding with a clear request is dropped
    assign wr_acc_c = ready & writeEnable & ~clear_req & addr_valid(rd);

    // Read data selection with optional forwarding of the accepted write
    always_comb begin
        rd1_c = '0;
        rd2_c = '0;
        if (addr_valid(rs1In)) begin
            if (BYPASS && wr_acc_c && (rd == rs1In)) begin
                rd1_c = data;
            end else begin
                rd1_c = regs[rs1In];
            end
        end
        if (addr_valid(rs2In)) begin
            if (BYPASS && wr_acc_c && (rd == rs2In)) begin
                rd2_c = data;
            end else begin
                rd2_c = regs[rs2In];
            end
        end
    end

    // Storage: zeroed by the clear walk, never by the async reset
    always_ff @(posedge clk) begin
        if (clear_en) begin
            regs[clear_idx] <= '0;
        end else if (wr_acc_c) begin
            regs[rd] <= data;
        end
    end

    // Registered read ports, held unless a read is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs1Out <= '0;
            rs2Out <= '0;
        end else if (ready && readEnable) begin
            rs1Out <= rd1_c;
            rs2Out <= rd2_c;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one forwarding instance and one
// non-forwarding instance driven by the same stimulus.
module tb_reg_file_mp;

    logic        clk;
    logic        reset;
    logic        clear_req;
    logic [4:0]  rs1In;
    logic [4:0]  rs2In;
    logic        readEnable;
    logic        writeEnable;
    logic [4:0]  rd;
    logic [31:0] data;

    logic        ready_a;
    logic [31:0] rs1_a;
    logic [31:0] rs2_a;
    logic        ready_b;
    logic [31:0] rs1_b;
    logic [31:0] rs2_b;

    int total = 0;
    int bad   = 0;

    reg_file_mp #(
        .XLEN(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_a),
        .rs1In(rs1In), .rs2In(rs2In), .readEnable(readEnable),
        .rs1Out(rs1_a), .rs2Out(rs2_a),
        .writeEnable(writeEnable), .rd(rd), .data(data)
    );

    reg_file_mp #(
        .XLEN(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b0)
    ) dut_nb (
        .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_b),
        .rs1In(rs1In), .rs2In(rs2In), .readEnable(readEnable),
        .rs1Out(rs1_b), .rs2Out(rs2_b),
        .writeEnable(writeEnable), .rd(rd), .data(data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear_req   = 1'b0;
        readEnable  = 1'b0;
        writeEnable = 1'b0;
    endtask

    // Both instances must agree on read data and ready
    task automatic chk_both(input string tag, input logic [31:0] e1, input logic [31:0] e2, input logic er);
        chk({tag, "_rs1_a"}, rs1_a, e1);
        chk({tag, "_rs2_a"}, rs2_a, e2);
        chk({tag, "_rs1_b"}, rs1_b, e1);
        chk({tag, "_rs2_b"}, rs2_b, e2);
        chk({tag, "_rdy_a"}, {31'b0, ready_a}, {31'b0, er});
        chk({tag, "_rdy_b"}, {31'b0, ready_b}, {31'b0, er});
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            readEnable = 1'b1;
            rs1In = 5'(a);
            rs2In = 5'(31 - a);
            tick();
            chk_both(tag, 32'h0, 32'h0, 1'b1);
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        rs1In = '0;
        rs2In = '0;
        rd    = '0;
        data  = '0;
        idle();

        // Reset state
        tick();
        tick();
        chk_both("reset", 32'h0, 32'h0, 1'b0);

        // Ready rises exactly 32 edges after release
        reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk({"init_clear_a"}, {31'b0, ready_a}, {31'b0, (i == 32)});
            chk({"init_clear_b"}, {31'b0, ready_b}, {31'b0, (i == 32)});
        end
        read_all_zero("init_zero");

        // Write then read next cycle
        writeEnable = 1'b1; rd = 5'd5; data = 32'hDEADBEEF;
        tick();
        idle();
        readEnable = 1'b1; rs1In = 5'd5; rs2In = 5'd0;
        tick();
        chk_both("wr_rd5", 32'hDEADBEEF, 32'h0, 1'b1);
        idle();

        // Same-cycle write/read: forwarded vs old contents
        writeEnable = 1'b1; rd = 5'd7; data = 32'h11111111;
        tick();
        writeEnable = 1'b1; rd = 5'd7; data = 32'h12345678;
        readEnable = 1'b1; rs1In = 5'd7; rs2In = 5'd5;
        tick();
        chk("byp_on",  rs1_a, 32'h12345678);
        chk("byp_off", rs1_b, 32'h11111111);
        chk("byp_rs2", rs2_a, 32'hDEADBEEF);
        idle();
        readEnable = 1'b1; rs1In = 5'd7; rs2In = 5'd7;
        tick();
        chk_both("after_byp", 32'h12345678, 32'h12345678, 1'b1);

        // Outputs hold when readEnable is low
        idle();
        rs1In = 5'd5; rs2In = 5'd0;
        tick();
        chk_both("hold", 32'h12345678, 32'h12345678, 1'b1);

        // Writes to r0 are dropped, even same-cycle
        writeEnable = 1'b1; rd = 5'd0; data = 32'hFFFFFFFF;
        readEnable = 1'b1; rs1In = 5'd0; rs2In = 5'd5;
        tick();
        chk_both("r0_same", 32'h0, 32'hDEADBEEF, 1'b1);
        idle();
        readEnable = 1'b1; rs1In = 5'd0; rs2In = 5'd0;
        tick();
        chk_both("r0_next", 32'h0, 32'h0, 1'b1);
        idle();

        // Fill r1..r31 with index*3
        for (int i = 1; i < 32; i++) begin
            writeEnable = 1'b1; rd = 5'(i); data = 32'(i * 3);
            tick();
        end
        idle();
        readEnable = 1'b1; rs1In = 5'd31; rs2In = 5'd1;
        tick();
        chk_both("fill", 32'd93, 32'd3, 1'b1);

        // Clear request with a colliding write; the read is still taken
        clear_req = 1'b1; readEnable = 1'b1; rs1In = 5'd10; rs2In = 5'd3;
        writeEnable = 1'b1; rd = 5'd3; data = 32'h000000AA;
        tick();
        chk_both("clr_entry", 32'd30, 32'd9, 1'b0);
        clear_req = 1'b0;
        writeEnable = 1'b1; rd = 5'd4; data = 32'h00000055;
        readEnable = 1'b1; rs1In = 5'd4; rs2In = 5'd4;
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk("clr_rdy_a", {31'b0, ready_a}, {31'b0, (i == 32)});
            chk("clr_rdy_b", {31'b0, ready_b}, {31'b0, (i == 32)});
        end
        idle();
        chk_both("clr_hold", 32'd30, 32'd9, 1'b1);
        read_all_zero("clr_zero");

        // Reset in the middle of a clear walk
        writeEnable = 1'b1; rd = 5'd9; data = 32'h00000099;
        tick();
        idle();
        clear_req = 1'b1; readEnable = 1'b1; rs1In = 5'd9; rs2In = 5'd9;
        tick();
        chk_both("mid_entry", 32'h99, 32'h99, 1'b0);
        idle();
        repeat (10) tick();
        #2;
        reset = 1'b1;
        #1;
        chk_both("mid_reset", 32'h0, 32'h0, 1'b0);
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk("rst_rdy_a", {31'b0, ready_a}, {31'b0, (i == 32)});
            chk("rst_rdy_b", {31'b0, ready_b}, {31'b0, (i == 32)});
        end
        readEnable = 1'b1; rs1In = 5'd9; rs2In = 5'd0;
        tick();
        chk_both("rst_r9", 32'h0, 32'h0, 1'b1);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
